pe_dma_desc_queue: RTL and testbench

Descriptor queue and sequencer directly upstream of the PE DMA controller. Host/scheduler pushes transfer descriptors through a valid/ready port into an internal FIFO. The sequencer pops one descriptor at a time, validates it, drives the DMA configuration bus, pulses dma_start, then waits for dma_done before launching the next. Completion and error counts plus a sticky interrupt are reported back to the host.

---
 rtl/pe_dma_desc_queue.sv | 184 ++++++++++++++++++
 tb/tb_pe_dma_desc_queue.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_dma_desc_queue.sv
// Descriptor FIFO and launch sequencer in front of the PE DMA controller.
// Optional S_WAIT watchdog: define PE_DMA_DESC_TIMEOUT_EN.
module pe_dma_desc_queue #(
  parameter int DEPTH          = 8,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     flush,
  input  logic                     desc_valid,
  output logic                     desc_ready,
  input  logic [31:0]              desc_src,
  input  logic [31:0]              desc_dst,
  input  logic [31:0]              desc_size,
  input  logic [31:0]              desc_src_stride,
  input  logic [31:0]              desc_dst_stride,
  input  logic [2:0]               desc_mode,
  output logic [31:0]              dma_src_addr,
  output logic [31:0]              dma_dst_addr,
  output logic [31:0]              dma_size,
  output logic [31:0]              dma_src_stride,
  output logic [31:0]              dma_dst_stride,
  output logic [2:0]               dma_mode,
  output logic                     dma_start,
  input  logic                     dma_done,
  input  logic                     dma_error,
  input  logic                     dma_busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         done_count,
  output logic [CNT_W-1:0]         err_count,
  output logic                     irq,
  input  logic                     irq_clr,
  output logic                     timeout,
  output logic                     idle
);
  // state   | meaning
  // S_IDLE  | pop/validate head when enabled and DMA not busy
  // S_START | dma_start high for this single cycle
  // S_WAIT  | transfer in flight, waiting for dma_done
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] size;
    logic [31:0] src_stride;
    logic [31:0] dst_stride;
    logic [2:0]  mode;
  } desc_t;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  desc_t          mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q, count_d;
  state_t         state_q;
  desc_t          head, cfg_q;
  logic           dma_start_q, irq_q;
  logic [CNT_W-1:0] done_q, err_q;
  logic           full, empty, push, pop, head_bad, irq_set, wd_expire;

  assign full       = (count_q == (AW+1)'(DEPTH));
  assign empty      = (count_q == '0);
  assign desc_ready = !full && !flush;
  assign push       = desc_valid && desc_ready;
  // flush wins over a same-cycle pop so nothing queued escapes the discard
  assign pop        = (state_q == S_IDLE) && enable && !empty && !dma_busy && !flush;
  assign head       = mem_q[rd_ptr_q];
  assign head_bad   = (head.size == '0) || (head.size[1:0] != 2'b00) ||
                      (head.src[1:0] != 2'b00) || (head.dst[1:0] != 2'b00);
  assign irq_set    = (pop && head_bad) || ((state_q == S_WAIT) && (dma_done || wd_expire));

  always_comb begin
    count_d = count_q;
    if (flush)              count_d = '0;
    else if (push && !pop)  count_d = count_q + (AW+1)'(1);
    else if (pop && !push)  count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {desc_src, desc_dst, desc_size, desc_src_stride, desc_dst_stride, desc_mode};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

`ifdef PE_DMA_DESC_TIMEOUT_EN
  localparam logic [31:0] WD_INIT = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] wd_q;
  logic        timeout_q;
  assign wd_expire = (state_q == S_WAIT) && !dma_done && (wd_q == '0);
  assign timeout   = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cfg_q       <= '0;
      dma_start_q <= 1'b0;
      done_q      <= '0;
      err_q       <= '0;
      irq_q       <= 1'b0;
`ifdef PE_DMA_DESC_TIMEOUT_EN
      wd_q        <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      dma_start_q <= 1'b0;
      irq_q       <= irq_set || (irq_q && !irq_clr);
`ifdef PE_DMA_DESC_TIMEOUT_EN
      timeout_q   <= wd_expire || (timeout_q && !irq_clr);
`endif
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            if (head_bad) begin
              err_q <= err_q + CNT_W'(1);
            end else begin
              cfg_q       <= head;
              dma_start_q <= 1'b1;
              state_q     <= S_START;
            end
          end
        end
        S_START: begin
          state_q <= S_WAIT;
`ifdef PE_DMA_DESC_TIMEOUT_EN
          wd_q    <= WD_INIT;
`endif
        end
        S_WAIT: begin
          if (dma_done) begin
            if (dma_error) err_q  <= err_q + CNT_W'(1);
            else           done_q <= done_q + CNT_W'(1);
            state_q <= S_IDLE;
          end else if (wd_expire) begin
            err_q   <= err_q + CNT_W'(1);
            state_q <= S_IDLE;
          end
`ifdef PE_DMA_DESC_TIMEOUT_EN
          else begin
            wd_q <= wd_q - 32'd1;
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dma_src_addr   = cfg_q.src;
  assign dma_dst_addr   = cfg_q.dst;
  assign dma_size       = cfg_q.size;
  assign dma_src_stride = cfg_q.src_stride;
  assign dma_dst_stride = cfg_q.dst_stride;
  assign dma_mode       = cfg_q.mode;
  assign dma_start      = dma_start_q;
  assign fifo_count     = count_q;
  assign done_count     = done_q;
  assign err_count      = err_q;
  assign irq            = irq_q;
  assign idle           = empty && (state_q == S_IDLE);
endmodule

// File: tb/tb_pe_dma_desc_queue.sv
// Bench for pe_dma_desc_queue: descriptor table, DMA responder and launch scoreboard.
module tb_pe_dma_desc_queue;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, flush = 1'b0, desc_valid = 1'b0, irq_clr = 1'b0;
  logic [31:0] desc_src = '0, desc_dst = '0, desc_size = '0, desc_src_stride = '0, desc_dst_stride = '0;
  logic [2:0]  desc_mode = '0;
  logic        desc_ready, dma_start, irq, timeout, idle;
  logic [31:0] dma_src_addr, dma_dst_addr, dma_size, dma_src_stride, dma_dst_stride;
  logic [2:0]  dma_mode;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [CNT_W-1:0] done_count, err_count;
  logic dma_done, dma_busy;
  logic done_main = 1'b0, busy_main = 1'b0, done_resp = 1'b0, busy_resp = 1'b0, dma_error = 1'b0;

  assign dma_done = done_main | done_resp;
  assign dma_busy = busy_main | busy_resp;

  always #5 clk = ~clk;

  pe_dma_desc_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_src(desc_src), .desc_dst(desc_dst), .desc_size(desc_size),
    .desc_src_stride(desc_src_stride), .desc_dst_stride(desc_dst_stride), .desc_mode(desc_mode),
    .dma_src_addr(dma_src_addr), .dma_dst_addr(dma_dst_addr), .dma_size(dma_size),
    .dma_src_stride(dma_src_stride), .dma_dst_stride(dma_dst_stride), .dma_mode(dma_mode),
    .dma_start(dma_start), .dma_done(dma_done), .dma_error(dma_error), .dma_busy(dma_busy),
    .fifo_count(fifo_count), .done_count(done_count), .err_count(err_count),
    .irq(irq), .irq_clr(irq_clr), .timeout(timeout), .idle(idle)
  );

  typedef struct packed {
    logic [31:0] src, dst, size, ss, ds;
    logic [2:0]  mode;
  } cfg_t;

  // DMA responder: logs every launch, raises busy, answers with done after resp_lat cycles
  cfg_t obs_q[$];
  int   n_starts = 0, bad_start = 0, cnt = 0, resp_lat = 3;
  bit   auto_resp = 1'b1, resp_err = 1'b0, prev_start = 1'b0;

  always @(negedge clk) begin
    done_resp = 1'b0;
    dma_error = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        done_resp = 1'b1;
        dma_error = resp_err;
        busy_resp = 1'b0;
      end
    end
    if (rst_n && dma_start) begin
      n_starts++;
      if (prev_start || busy_resp || busy_main) bad_start++;
      obs_q.push_back({dma_src_addr, dma_dst_addr, dma_size, dma_src_stride, dma_dst_stride, dma_mode});
      if (auto_resp) begin
        busy_resp = 1'b1;
        cnt = resp_lat;
      end
    end
    prev_start = dma_start;
  end

  int   n_vec = 0, n_err = 0, obs_rd = 0;
  int   exp_done = 0, exp_err = 0, exp_nstart = 0;
  cfg_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] s, input logic [31:0] d, input logic [31:0] z);
    return (z == 0) || (z[1:0] != 2'b00) || (s[1:0] != 2'b00) || (d[1:0] != 2'b00);
  endfunction

  task automatic set_fields(input logic [31:0] s, input logic [31:0] d, input logic [31:0] z);
    desc_src = s; desc_dst = d; desc_size = z;
    desc_src_stride = s ^ 32'h0000_0F00;
    desc_dst_stride = d + 32'h40;
    desc_mode = z[4:2];
  endtask

  task automatic record();
    if (is_bad(desc_src, desc_dst, desc_size)) exp_err++;
    else begin
      exp_q.push_back({desc_src, desc_dst, desc_size, desc_src_stride, desc_dst_stride, desc_mode});
      exp_nstart++;
    end
  endtask

  task automatic push_one(input logic [31:0] s, input logic [31:0] d, input logic [31:0] z);
    bit ok = 1'b0;
    set_fields(s, d, z);
    desc_valid = 1'b1;
    #1;
    for (int i = 0; i < 200; i++) begin
      if (desc_ready) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    if (ok) record();
    else chk("push_ready_wait", 64'd0, 64'd1);
    @(negedge clk);
    desc_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    @(negedge clk);
    for (int i = 0; i < budget; i++) begin
      if (idle) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) chk("wait_idle_expired", 64'd0, 64'd1);
  endtask

  task automatic check_starts();
    while (obs_rd < obs_q.size()) begin
      cfg_t o = obs_q[obs_rd];
      obs_rd++;
      if (exp_q.size() == 0) chk("unexpected_start", 64'd1, 64'd0);
      else begin
        cfg_t e = exp_q.pop_front();
        chk("cfg_src", o.src, e.src);
        chk("cfg_dst", o.dst, e.dst);
        chk("cfg_size", o.size, e.size);
        chk("cfg_src_stride", o.ss, e.ss);
        chk("cfg_dst_stride", o.ds, e.ds);
        chk("cfg_mode", o.mode, e.mode);
      end
    end
  endtask

  typedef struct {
    logic [31:0] src, dst, size;
    bit          exp_start;
  } vec_t;
  vec_t vt[7];

  initial begin
    vt[0] = '{32'h100,  32'h200,  32'd16,        1'b1};
    vt[1] = '{32'h100,  32'h200,  32'd0,         1'b0};
    vt[2] = '{32'h100,  32'h200,  32'd6,         1'b0};
    vt[3] = '{32'h102,  32'h200,  32'd16,        1'b0};
    vt[4] = '{32'h300,  32'h203,  32'd8,         1'b0};
    vt[5] = '{32'h1000, 32'h2000, 32'd4,         1'b1};
    vt[6] = '{32'h4,    32'h8,    32'hFFFF_FFFC, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_idle_in_reset", idle, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_desc_ready", desc_ready, 1);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_done_count", done_count, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_irq", irq, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_idle", idle, 1);
    chk("rst_dma_start", dma_start, 0);
    chk("rst_dma_src", dma_src_addr, 0);
    chk("rst_dma_size", dma_size, 0);

    // table: validation and single launches
    enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      push_one(vt[i].src, vt[i].dst, vt[i].size);
      if (vt[i].exp_start) exp_done++;
      wait_idle(60);
      check_starts();
      chk($sformatf("vec%0d_err_count", i), err_count, exp_err);
      chk($sformatf("vec%0d_done_count", i), done_count, exp_done);
      chk($sformatf("vec%0d_starts", i), n_starts, exp_nstart);
      chk($sformatf("vec%0d_irq", i), irq, 1);
      chk($sformatf("vec%0d_held_size", i), dma_size, (i == 6) ? 32'hFFFF_FFFC : ((i == 5) ? 32'd4 : 32'd16));
      irq_clr = 1'b1;
      @(negedge clk);
      irq_clr = 1'b0;
      chk($sformatf("vec%0d_irq_clr", i), irq, 0);
    end

    // fill past DEPTH with sequencer disabled, then drain under busy gating
    enable = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_fields(32'h1000 + 32'(i * 16), 32'h8000 + 32'(i * 32), 32'd64 + 32'(i * 4));
      desc_valid = 1'b1;
      #1;
      chk($sformatf("fill%0d_ready", i), desc_ready, (i < 8) ? 1 : 0);
      if (desc_ready) record();
      @(negedge clk);
    end
    desc_valid = 1'b0;
    chk("fill_count", fifo_count, 8);
    chk("fill_not_idle", idle, 0);
    busy_main = 1'b1;
    enable = 1'b1;
    repeat (6) @(negedge clk);
    chk("busy_blocks_start", n_starts, exp_nstart - 8);
    chk("busy_count_held", fifo_count, 8);
    busy_main = 1'b0;
    exp_done += 8;
    wait_idle(400);
    check_starts();
    chk("drain_done_count", done_count, exp_done);
    chk("drain_fifo_empty", fifo_count, 0);

    // DMA-reported error, then irq_clr colliding with a completion
    resp_err = 1'b1;
    push_one(32'h40, 32'h80, 32'd32);
    wait_idle(60);
    check_starts();
    exp_nstart--; exp_nstart++;
    exp_err++;
    chk("dmaerr_err_count", err_count, exp_err);
    chk("dmaerr_done_count", done_count, exp_done);
    chk("dmaerr_irq", irq, 1);
    resp_err = 1'b0;
    irq_clr = 1'b1;
    push_one(32'h44, 32'h88, 32'd8);
    for (int i = 0; i < 60; i++) begin
      if (done_count == CNT_W'(exp_done + 1)) break;
      @(negedge clk);
    end
    exp_done++;
    chk("clr_collide_done", done_count, exp_done);
    chk("clr_collide_irq_set_wins", irq, 1);
    @(negedge clk);
    chk("clr_after_collide", irq, 0);
    irq_clr = 1'b0;
    check_starts();

    // flush with one transfer in flight
    resp_lat = 20;
    enable = 1'b0;
    for (int i = 0; i < 4; i++) push_one(32'h5000 + 32'(i * 4), 32'h6000, 32'd12);
    chk("flush_pre_count", fifo_count, 4);
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (dma_start) break;
      @(negedge clk);
    end
    chk("flush_launch_seen", dma_start, 1);
    chk("flush_count_after_pop", fifo_count, 3);
    flush = 1'b1;
    set_fields(32'h7000, 32'h7100, 32'd16);
    desc_valid = 1'b1;
    #1;
    chk("flush_ready_low", desc_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    desc_valid = 1'b0;
    chk("flush_count_zero", fifo_count, 0);
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    exp_nstart -= 3;
    exp_done++;
    wait_idle(100);
    repeat (20) @(negedge clk);
    check_starts();
    chk("flush_inflight_done", done_count, exp_done);
    chk("flush_no_more_starts", n_starts, exp_nstart);
    chk("flush_idle", idle, 1);
    resp_lat = 3;

    // withheld dma_done
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    auto_resp = 1'b0;
    push_one(32'h900, 32'hA00, 32'd20);
    for (int i = 0; i < 20; i++) begin
      if (dma_start) break;
      @(negedge clk);
    end
    chk("wd_launch_seen", dma_start, 1);
`ifdef PE_DMA_DESC_TIMEOUT_EN
    repeat (10) @(negedge clk);
    chk("wd_before_expire_timeout", timeout, 0);
    chk("wd_before_expire_irq", irq, 0);
    chk("wd_before_expire_busy", idle, 0);
    @(negedge clk);
    exp_err++;
    chk("wd_timeout", timeout, 1);
    chk("wd_err_count", err_count, exp_err);
    chk("wd_idle", idle, 1);
    chk("wd_irq", irq, 1);
    done_main = 1'b1;
    @(negedge clk);
    done_main = 1'b0;
    repeat (3) @(negedge clk);
    chk("wd_stray_done_cnt", done_count, exp_done);
    chk("wd_stray_err_cnt", err_count, exp_err);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    chk("wd_timeout_cleared", timeout, 0);
`else
    repeat (50) @(negedge clk);
    chk("nowd_timeout", timeout, 0);
    chk("nowd_still_waiting", idle, 0);
    chk("nowd_done_unchanged", done_count, exp_done);
    done_main = 1'b1;
    @(negedge clk);
    done_main = 1'b0;
    @(negedge clk);
    exp_done++;
    chk("nowd_late_done", done_count, exp_done);
    chk("nowd_idle", idle, 1);
`endif
    check_starts();
    auto_resp = 1'b1;

    chk("no_bad_start", bad_start, 0);
    chk("no_missing_start", exp_q.size(), 0);
    chk("total_starts", n_starts, exp_nstart);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got expired, want finished");
    $fatal(1, "time limit");
  end
endmodule
